// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM states, nibble width and overflow helper for nibble_serial_addsub
package addsub_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam int NIBBLE_W = 4;

   function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/nibble_addsub.sv
// nibble_addsub: combinational 4-bit adder slice with carry in/out
module nibble_addsub
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   assign {cout, s} = a + b + cin;

endmodule

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/sub computed one nibble per clock, LSB first; define ADDSUB_SAT_EN for saturating signed results
module nibble_serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int            NIBBLES = WIDTH / NIBBLE_W;
   localparam int            CW      = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST    = CW'(NIBBLES - 1);

   if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_width_check
      $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
   end

   state_t                r_state, w_next;
   logic [WIDTH-1:0]      r_a, r_b, r_sum;
   logic [WIDTH-NIBBLE_W-1:0] r_acc;
   logic [CW-1:0]         r_cnt;
   logic                  r_carry, r_cout, r_ovf, r_zero;
   logic [NIBBLE_W-1:0]   w_s;
   logic                  w_c, w_last, w_ovf, w_take;
   logic [WIDTH-1:0]      w_cat, w_res;

   // one shared slice; operands shift right so the live nibble is always at the bottom
   nibble_addsub u_nib (
      .a    (r_a[NIBBLE_W-1:0]),
      .b    (r_b[NIBBLE_W-1:0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_c)
   );

   assign w_take = in_valid && in_ready;
   assign w_last = (r_cnt == LAST);
   assign w_cat  = {w_s, r_acc};
   assign w_ovf  = ovf_f(r_a[NIBBLE_W-1], r_b[NIBBLE_W-1], w_s[NIBBLE_W-1]);

`ifdef ADDSUB_SAT_EN
   assign w_res = w_ovf ? {r_a[NIBBLE_W-1], {(WIDTH-1){~r_a[NIBBLE_W-1]}}} : w_cat;
`else
   assign w_res = w_cat;
`endif

   assign in_ready  = rst_n && (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;
   assign out_zero  = r_zero;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // next-state: accept in IDLE, leave CALC after the top nibble, leave DONE on consumer handshake
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE && w_take)    ? CALC :
               (r_state == CALC && w_last)    ? DONE :
               (r_state == DONE && out_ready) ? IDLE : r_state;
   end

   // operand capture, per-nibble accumulation, and result/flag update on the final nibble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_take) begin
         r_a     <= in_a;
         r_b     <= in_b ^ {WIDTH{in_sub}};
         r_carry <= in_sub;
         r_cnt   <= '0;
      end else if (r_state == CALC) begin
         r_a     <= r_a >> NIBBLE_W;
         r_b     <= r_b >> NIBBLE_W;
         r_acc   <= w_cat[WIDTH-1:NIBBLE_W];
         r_carry <= w_c;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_sum  <= w_res;
            r_cout <= w_c;
            r_ovf  <= w_ovf;
            r_zero <= ~|w_res;
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb_nibble_serial_addsub: directed vectors with hand-computed results for nibble_serial_addsub (WIDTH=16)
module tb_nibble_serial_addsub;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, out_cout, out_ovf, out_zero;
   logic [15:0] in_a = '0, in_b = '0, out_sum;
   int          n_chk = 0, n_fail = 0;
   logic        seen;

   always #5 clk = ~clk;

   nibble_serial_addsub #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic start(input logic [15:0] a, input logic [15:0] b, input logic s);
      in_a = a;
      in_b = b;
      in_sub = s;
      in_valid = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         in_valid = 1'b0;
         if (lat == 1) chk({tag, " busy"}, {out_valid, in_ready}, 2'b00);
      end while (!out_valid && lat < 20);
      chk({tag, " latency"}, lat, 5);
   endtask

   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] e_sum, input logic e_c, input logic e_v, input logic e_z);
      chk({tag, " ready"}, in_ready, 1);
      start(a, b, s);
      wait_done(tag);
      chk({tag, " sum"}, out_sum, e_sum);
      chk({tag, " flags"}, {out_cout, out_ovf, out_zero}, {e_c, e_v, e_z});
      @(posedge clk);
      @(negedge clk);
      chk({tag, " release"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      #2;
      chk("rst in_ready", in_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst outputs", {out_sum, out_cout, out_ovf, out_zero}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("add1",     16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0);
      run("sub_pos",  16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
      run("sub_neg",  16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run("ovf_add",  16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
      run("ovf_sub",  16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run("zero_sub", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      run("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      run("neg_ovf",  16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT);
      out_ready = 1'b0;
      start(16'h1111, 16'h2222, 1'b0);
      wait_done("bp");
      chk("bp sum", out_sum, 16'h3333);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a = 16'(i * 16'h1111);
         in_b = ~in_a;
         in_sub = i[0];
         @(posedge clk);
         @(negedge clk);
         chk("bp hold", {out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero},
             {1'b1, 1'b0, 16'h3333, 3'b000});
      end
      in_a = 16'h0100;
      in_b = 16'h0200;
      in_sub = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp release", {out_valid, in_ready}, 2'b01);
      wait_done("pend");
      chk("pend sum", out_sum, 16'h0300);
      chk("pend flags", {out_cout, out_ovf, out_zero}, 3'b000);
      @(posedge clk);
      @(negedge clk);
      start(16'h1234, 16'h0FF0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort outputs", {out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      chk("abort no valid", seen, 0);
      run("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
